alu_writeback: RTL
==================

// Module: alu_writeback
// PURPOSE
//  Integer writeback stage directly downstream of the add/sub/compare unit.
//  Pairs each addsub result with the destination tag captured at issue.
//  Merges it with results from the multi-cycle multiplier onto the single
//  register-file write port. Raises the arithmetic trap for /V overflow and
//  exports a pending-destination mask for issue interlock.
// PARAMETERS
//  DW        64  result / register data width
//  RAW        5  register address width
//  ZERO_REG  31  hardwired-zero register; writes to it are suppressed
// PORTS
//  clk         in   1    core clock
//  reset       in   1    synchronous, active-high reset
//  flush       in   1    pipeline flush; kills addsub ops not yet written
//  as_issue    in   1    addsub enable pulse (same cycle addsub latches operands)
//  as_dest     in   RAW  destination register of issued addsub op
//  as_trap_en  in   1    op is /V: overflow must trap
//  as_rvalid   in   1    addsub result valid
//  as_result   in   DW   addsub result
//  as_ovflow   in   1    addsub overflow flag
//  mul_valid   in   1    multiplier result valid (held until accepted)
//  mul_dest    in   RAW  multiplier destination register
//  mul_result  in   DW   multiplier result
//  mul_ready   out  1    combinational: ~as_rvalid | flush
//  rf_we       out  1    register-file write enable
//  rf_waddr    out  RAW  register-file write address
//  rf_wdata    out  DW   register-file write data
//  trap_arith  out  1    one-cycle arithmetic-trap pulse, aligned with the write slot
//  trap_reg    out  RAW  destination of trapping op; valid with trap_arith
//  pend_mask   out  32   bit r set: addsub op to r issued, not yet written
//  err_orphan  out  1    sticky: as_rvalid seen with no tag in stage 1
// BEHAVIOUR
//  - Reset: all outputs 0; tag stages invalid; err_orphan 0.
//  - Stage T1 {v1,d1,t1}: loaded from as_issue/as_dest/as_trap_en every cycle.
//    v1 <= as_issue & ~flush.
//  - Stage T2/write register:
//    - as_rvalid & v1 & ~flush: loads {d1, as_result, t1 & as_ovflow}.
//      The addsub write slot is the cycle after as_rvalid.
//    - as_rvalid & ~v1 & ~flush: result dropped; err_orphan <= 1.
//  - Latency: issue at t, as_rvalid at t+1, rf_we/trap at t+2.
//    Back-to-back issue every cycle sustains one write per cycle.
//  - Arbitration: addsub has absolute priority (it cannot stall).
//    - mul_ready = ~as_rvalid | flush; mul accepted on mul_valid & mul_ready.
//    - Accepted mul result: rf_waddr=mul_dest, rf_wdata=mul_result next cycle.
//    - Mul never traps.
//  - flush: clears v1. A result arriving in the flush cycle is dropped
//    (no write, no trap, no orphan flag). Writes already in T2 complete.
//    Mul acceptance is unaffected by flush.
//  - Zero register: rf_we=0 when waddr==ZERO_REG.
//    trap_arith still asserts for ZERO_REG; rf_waddr/rf_wdata still driven.
//  - Overflow: the trapping result is still written (Alpha /V semantics).
//    trap_arith=1 and trap_reg=dest in the same cycle as rf_we.
//  - pend_mask: combinational decode.
//    - OR of (v1 ? 1<<d1) and (T2 addsub-valid ? 1<<d2); ZERO_REG bit always 0.
//    - Equal d1==d2 keeps the bit set until both are retired.
//  - No write slot: rf_we=0, trap_arith=0; rf_waddr/rf_wdata hold last value.
//  - Reset mid-operation: all in-flight tags and pending writes are discarded
//    next cycle. err_orphan is cleared only by reset.
// TESTING
//  1. Issue d=3, then as_rvalid result=0x1234 -> at t+2: rf_we=1,
//     waddr=3, wdata=0x1234; pend_mask bit3 set for t+1..t+2 only.
//  2. Back-to-back issues d=5,d=5,d=6 -> three writes on consecutive cycles
//     in order; pend_mask bit5 set continuously until the 2nd write.
//  3. mul_valid held (d=7, 0xBEEF) while as_rvalid high 2 cycles ->
//     mul_ready=0 those cycles; mul written in the cycle after as_rvalid drops.
//  4. /V issue d=9, as_ovflow=1 -> rf_we=1 and trap_arith=1 with trap_reg=9.
//     Same with as_trap_en=0 -> write only, no trap.
//  5. Issue d=31 with overflow trap -> rf_we=0, trap_arith=1, trap_reg=31,
//     pend_mask always 0.
//  6. flush in the cycle of as_rvalid -> no write, err_orphan stays 0.
//     Unpaired as_rvalid -> err_orphan=1 until reset.

Source files
------------

// File: rtl/alu_writeback.sv
// Writeback stage for the add/sub/compare unit: pairs results with issue-time tags,
// merges multiplier results onto the single register-file write port, raises /V traps.
module alu_writeback #(
  parameter int DW       = 64,
  parameter int RAW      = 5,
  parameter int ZERO_REG = 31
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           flush,
  input  logic           as_issue,
  input  logic [RAW-1:0] as_dest,
  input  logic           as_trap_en,
  input  logic           as_rvalid,
  input  logic [DW-1:0]  as_result,
  input  logic           as_ovflow,
  input  logic           mul_valid,
  input  logic [RAW-1:0] mul_dest,
  input  logic [DW-1:0]  mul_result,
  output logic           mul_ready,
  output logic           rf_we,
  output logic [RAW-1:0] rf_waddr,
  output logic [DW-1:0]  rf_wdata,
  output logic           trap_arith,
  output logic [RAW-1:0] trap_reg,
  output logic [31:0]    pend_mask,
  output logic           err_orphan
);

  localparam logic [RAW-1:0] ZERO_ADDR = RAW'(ZERO_REG);

  // Stage T1: tag captured at issue
  logic           v1_reg;
  logic [RAW-1:0] d1_reg;
  logic           t1_reg;

  // Stage T2: the write slot
  logic           as_v2_reg;
  logic [RAW-1:0] d2_reg;
  logic           we_reg;
  logic [RAW-1:0] waddr_reg;
  logic [DW-1:0]  wdata_reg;
  logic           trap_reg_q;
  logic           orphan_reg;

  logic as_load;
  logic as_orphan;
  logic mul_take;

  always_comb begin
    as_load   = as_rvalid & v1_reg & ~flush;
    as_orphan = as_rvalid & ~v1_reg & ~flush;
    mul_ready = ~as_rvalid | flush;
    mul_take  = mul_valid & mul_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_reg     <= 1'b0;
      d1_reg     <= '0;
      t1_reg     <= 1'b0;
      as_v2_reg  <= 1'b0;
      d2_reg     <= '0;
      we_reg     <= 1'b0;
      waddr_reg  <= '0;
      wdata_reg  <= '0;
      trap_reg_q <= 1'b0;
      orphan_reg <= 1'b0;
    end else begin
      v1_reg     <= as_issue & ~flush;
      d1_reg     <= as_dest;
      t1_reg     <= as_trap_en;
      as_v2_reg  <= as_load;
      trap_reg_q <= as_load & t1_reg & as_ovflow;
      if (as_orphan)
        orphan_reg <= 1'b1;
      // addsub cannot stall, so it owns the slot whenever it has a result
      if (as_load) begin
        d2_reg    <= d1_reg;
        waddr_reg <= d1_reg;
        wdata_reg <= as_result;
        we_reg    <= (d1_reg != ZERO_ADDR);
      end else if (mul_take) begin
        waddr_reg <= mul_dest;
        wdata_reg <= mul_result;
        we_reg    <= (mul_dest != ZERO_ADDR);
      end else begin
        we_reg    <= 1'b0;
      end
    end
  end

  assign rf_we      = we_reg;
  assign rf_waddr   = waddr_reg;
  assign rf_wdata   = wdata_reg;
  assign trap_arith = trap_reg_q;
  assign trap_reg   = d2_reg;
  assign err_orphan = orphan_reg;

  // Both stages contribute independently, so equal tags keep the bit until both retire
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_pend
      if (gi == ZERO_REG) begin : g_zero
        assign pend_mask[gi] = 1'b0;
      end else begin : g_reg
        assign pend_mask[gi] = (v1_reg && (d1_reg == RAW'(gi))) ||
                               (as_v2_reg && (d2_reg == RAW'(gi)));
      end
    end
  endgenerate

endmodule
